// File: rtl/mem_ctrl_pkg.sv
// Shared opcodes, access sizes, FSM states and fault codes for the load/store sequencer.
package mem_ctrl_pkg;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;

  // FUNCT3[1:0] encodes the access size; FUNCT3[2] selects zero-extension on loads.
  localparam logic [1:0] SizeB = 2'd0;
  localparam logic [1:0] SizeH = 2'd1;
  localparam logic [1:0] SizeW = 2'd2;
  localparam logic [1:0] SizeD = 2'd3;

  typedef enum logic [2:0] {StIdle, StReq, StWait, StDone, StFlt} state_e;

  typedef enum logic [1:0] {
    CauseNone     = 2'b00,
    CauseMisalign = 2'b01,
    CauseTimeout  = 2'b10,
    CauseIllegal  = 2'b11
  } cause_e;

  function automatic logic width_illegal(input logic [2:0] funct3, input logic is_store,
                                         input int unsigned xlen);
    logic wide_only;
    wide_only = (funct3 == 3'b011) || (funct3 == 3'b110);
    return (funct3 == 3'b111) || (is_store && funct3[2]) || (wide_only && xlen != 64);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads (purely combinational).
module mem_lane_align import mem_ctrl_pkg::*; #(
  parameter  int unsigned XLEN          = 32,
  parameter  int unsigned MISALIGN_TRAP = 1,
  localparam int unsigned NB            = XLEN / 8,
  localparam int unsigned OffW          = $clog2(NB)
) (
  input  logic [OffW-1:0] addr_off,
  input  logic [1:0]      size,
  input  logic [XLEN-1:0] wdata,
  input  logic [OffW-1:0] ld_off,
  input  logic [2:0]      ld_funct3,
  input  logic [XLEN-1:0] rdata,
  output logic            misaligned,
  output logic [OffW-1:0] off_eff,
  output logic [NB-1:0]   be,
  output logic [XLEN-1:0] mwdata,
  output logic [XLEN-1:0] ldata
);

  logic [OffW-1:0] align_mask;
  logic [NB-1:0]   be_base;
  logic [XLEN-1:0] shifted;

  always_comb begin
    align_mask = '1;
    be_base    = '1;
    mwdata     = wdata;
    unique case (size)
      SizeB: begin
        align_mask = '0;
        be_base    = NB'(1);
        mwdata     = {NB{wdata[7:0]}};
      end
      SizeH: begin
        align_mask = OffW'(1);
        be_base    = NB'(3);
        mwdata     = {(NB / 2){wdata[15:0]}};
      end
      SizeW: begin
        align_mask = OffW'(3);
        be_base    = NB'(15);
        mwdata     = {(NB / 4){wdata[31:0]}};
      end
      default: ;
    endcase
    misaligned = |(addr_off & align_mask);
    // Without trapping, the low offset bits are simply rounded down to the access size.
    off_eff    = (MISALIGN_TRAP != 0) ? addr_off : (addr_off & ~align_mask);
    be         = be_base << off_eff;
  end

  always_comb begin
    shifted = rdata >> {ld_off, 3'b000};
    unique case (ld_funct3[1:0])
      SizeB: begin
        if (ld_funct3[2]) ldata = XLEN'(shifted[7:0]);
        else              ldata = XLEN'($signed(shifted[7:0]));
      end
      SizeH: begin
        if (ld_funct3[2]) ldata = XLEN'(shifted[15:0]);
        else              ldata = XLEN'($signed(shifted[15:0]));
      end
      SizeW: begin
        if (ld_funct3[2]) ldata = XLEN'(shifted[31:0]);
        else              ldata = XLEN'($signed(shifted[31:0]));
      end
      default: ldata = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle load/store sequencer: stalls the core, drives request strobes for REQ_CYCLES,
// waits for RDY with an optional timeout and reports misaligned/illegal/timeout faults.
module mem_access_ctrl import mem_ctrl_pkg::*; #(
  parameter  int unsigned XLEN          = 32,
  parameter  int unsigned ADDR_W        = 32,
  parameter  int unsigned REQ_CYCLES    = 1,
  parameter  int unsigned TIMEOUT       = 255,
  parameter  int unsigned MISALIGN_TRAP = 1,
  localparam int unsigned NB            = XLEN / 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [6:0]        OPCODE,
  input  logic [2:0]        FUNCT3,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [XLEN-1:0]   WDATA,
  input  logic              RDY,
  input  logic [XLEN-1:0]   RDATA_MEM,
  output logic              HOLD,
  output logic              RREQ,
  output logic              CWE,
  output logic [NB-1:0]     BE,
  output logic [ADDR_W-1:0] MADDR,
  output logic [XLEN-1:0]   MWDATA,
  output logic [XLEN-1:0]   LDATA,
  output logic              LWE,
  output logic              FAULT,
  output logic [1:0]        FAULT_CAUSE
);

  localparam int unsigned OffW = $clog2(NB);

  state_e            state_q, state_d;
  cause_e            cause_q, cause_d;
  logic              is_store_q;
  logic [2:0]        f3_q;
  logic [OffW-1:0]   off_q;
  logic [ADDR_W-1:0] maddr_q;
  logic [NB-1:0]     be_q;
  logic [XLEN-1:0]   mwdata_q, ldata_q;
  logic [31:0]       req_cnt_q, wait_cnt_q;
  logic              rdy_seen_q;

  logic              is_store, is_mem, illegal, misaligned, req_last, timeout_hit, capture;
  logic [OffW-1:0]   off_eff;
  logic [NB-1:0]     be_new;
  logic [XLEN-1:0]   mwdata_new, ldata_ext;

  mem_lane_align #(
    .XLEN         (XLEN),
    .MISALIGN_TRAP(MISALIGN_TRAP)
  ) u_lane_align (
    .addr_off  (ADDR[OffW-1:0]),
    .size      (FUNCT3[1:0]),
    .wdata     (WDATA),
    .ld_off    (off_q),
    .ld_funct3 (f3_q),
    .rdata     (RDATA_MEM),
    .misaligned(misaligned),
    .off_eff   (off_eff),
    .be        (be_new),
    .mwdata    (mwdata_new),
    .ldata     (ldata_ext)
  );

  assign is_store    = (OPCODE == OpStore);
  assign is_mem      = (OPCODE == OpLoad) || is_store;
  assign illegal     = width_illegal(FUNCT3, is_store, XLEN);
  assign req_last    = (req_cnt_q == REQ_CYCLES - 1);
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == TIMEOUT - 1);
  assign capture     = RDY && !is_store_q && (state_q == StReq || state_q == StWait);

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      StIdle: begin
        if (is_mem) begin
          if (illegal) begin
            state_d = StFlt;
            cause_d = CauseIllegal;
          end else if (misaligned && MISALIGN_TRAP != 0) begin
            state_d = StFlt;
            cause_d = CauseMisalign;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (req_last) state_d = (rdy_seen_q || RDY) ? StDone : StWait;
      end
      StWait: begin
        // RDY takes priority over a timeout landing in the same cycle.
        if (RDY) begin
          state_d = StDone;
        end else if (timeout_hit) begin
          state_d = StFlt;
          cause_d = CauseTimeout;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign HOLD        = !RST && is_mem && (state_q != StDone) && (state_q != StFlt);
  assign RREQ        = (state_q == StReq) && !is_store_q;
  assign CWE         = (state_q == StReq) && is_store_q;
  assign LWE         = (state_q == StDone) && !is_store_q;
  assign FAULT       = (state_q == StFlt);
  assign FAULT_CAUSE = cause_q;
  assign BE          = be_q;
  assign MADDR       = maddr_q;
  assign MWDATA      = mwdata_q;
  assign LDATA       = ldata_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      cause_q    <= CauseNone;
      is_store_q <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      maddr_q    <= '0;
      be_q       <= '0;
      mwdata_q   <= '0;
      ldata_q    <= '0;
      req_cnt_q  <= '0;
      wait_cnt_q <= '0;
      rdy_seen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (state_q == StIdle && state_d == StReq) begin
        is_store_q <= is_store;
        f3_q       <= FUNCT3;
        off_q      <= off_eff;
        maddr_q    <= {ADDR[ADDR_W-1:OffW], {OffW{1'b0}}};
        be_q       <= be_new;
        mwdata_q   <= mwdata_new;
        req_cnt_q  <= '0;
        wait_cnt_q <= '0;
        rdy_seen_q <= 1'b0;
      end
      if (state_q == StReq) begin
        req_cnt_q  <= req_cnt_q + 32'd1;
        rdy_seen_q <= rdy_seen_q || RDY;
      end
      if (state_q == StWait) wait_cnt_q <= wait_cnt_q + 32'd1;
      if (capture) ldata_q <= ldata_ext;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench: three differently-parametrised sequencers against a lane/latency model.
module tb_mem_access_ctrl;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] NOP   = 7'b0010011;

  // Instance 0: XLEN32 REQ2 TO4 trap; 1: XLEN32 REQ1 TO4 no-trap; 2: XLEN64 REQ1 TO6 trap.
  localparam int unsigned PXLEN [3] = '{32, 32, 64};
  localparam int unsigned PREQ  [3] = '{2, 1, 1};
  localparam int unsigned PTO   [3] = '{4, 4, 6};
  localparam int unsigned PTRAP [3] = '{1, 0, 1};

  logic        clk, rst, rdy;
  logic [6:0]  op_a, op_b, op_c;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [63:0] wdata, rdata;

  logic        hold_a, rreq_a, cwe_a, lwe_a, fault_a;
  logic        hold_b, rreq_b, cwe_b, lwe_b, fault_b;
  logic        hold_c, rreq_c, cwe_c, lwe_c, fault_c;
  logic [1:0]  cause_a, cause_b, cause_c;
  logic [3:0]  be_a, be_b;
  logic [7:0]  be_c;
  logic [31:0] maddr_a, maddr_b, maddr_c;
  logic [31:0] mwdata_a, mwdata_b, ldata_a, ldata_b;
  logic [63:0] mwdata_c, ldata_c;

  mem_access_ctrl #(.XLEN(32), .ADDR_W(32), .REQ_CYCLES(2), .TIMEOUT(4), .MISALIGN_TRAP(1)) u_a (
    .CLK(clk), .RST(rst), .OPCODE(op_a), .FUNCT3(f3), .ADDR(addr), .WDATA(wdata[31:0]),
    .RDY(rdy), .RDATA_MEM(rdata[31:0]), .HOLD(hold_a), .RREQ(rreq_a), .CWE(cwe_a), .BE(be_a),
    .MADDR(maddr_a), .MWDATA(mwdata_a), .LDATA(ldata_a), .LWE(lwe_a), .FAULT(fault_a),
    .FAULT_CAUSE(cause_a)
  );

  mem_access_ctrl #(.XLEN(32), .ADDR_W(32), .REQ_CYCLES(1), .TIMEOUT(4), .MISALIGN_TRAP(0)) u_b (
    .CLK(clk), .RST(rst), .OPCODE(op_b), .FUNCT3(f3), .ADDR(addr), .WDATA(wdata[31:0]),
    .RDY(rdy), .RDATA_MEM(rdata[31:0]), .HOLD(hold_b), .RREQ(rreq_b), .CWE(cwe_b), .BE(be_b),
    .MADDR(maddr_b), .MWDATA(mwdata_b), .LDATA(ldata_b), .LWE(lwe_b), .FAULT(fault_b),
    .FAULT_CAUSE(cause_b)
  );

  mem_access_ctrl #(.XLEN(64), .ADDR_W(32), .REQ_CYCLES(1), .TIMEOUT(6), .MISALIGN_TRAP(1)) u_c (
    .CLK(clk), .RST(rst), .OPCODE(op_c), .FUNCT3(f3), .ADDR(addr), .WDATA(wdata),
    .RDY(rdy), .RDATA_MEM(rdata), .HOLD(hold_c), .RREQ(rreq_c), .CWE(cwe_c), .BE(be_c),
    .MADDR(maddr_c), .MWDATA(mwdata_c), .LDATA(ldata_c), .LWE(lwe_c), .FAULT(fault_c),
    .FAULT_CAUSE(cause_c)
  );

  int          sel;
  logic        o_hold, o_rreq, o_cwe, o_lwe, o_fault;
  logic [1:0]  o_cause;
  logic [7:0]  o_be;
  logic [31:0] o_maddr;
  logic [63:0] o_mwdata, o_ldata;

  always_comb begin
    case (sel)
      0: begin
        o_hold = hold_a; o_rreq = rreq_a; o_cwe = cwe_a; o_lwe = lwe_a; o_fault = fault_a;
        o_cause = cause_a; o_be = {4'h0, be_a}; o_maddr = maddr_a;
        o_mwdata = {32'h0, mwdata_a}; o_ldata = {32'h0, ldata_a};
      end
      1: begin
        o_hold = hold_b; o_rreq = rreq_b; o_cwe = cwe_b; o_lwe = lwe_b; o_fault = fault_b;
        o_cause = cause_b; o_be = {4'h0, be_b}; o_maddr = maddr_b;
        o_mwdata = {32'h0, mwdata_b}; o_ldata = {32'h0, ldata_b};
      end
      default: begin
        o_hold = hold_c; o_rreq = rreq_c; o_cwe = cwe_c; o_lwe = lwe_c; o_fault = fault_c;
        o_cause = cause_c; o_be = be_c; o_maddr = maddr_c;
        o_mwdata = mwdata_c; o_ldata = ldata_c;
      end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] m_ldata [3];
  logic [1:0]  m_cause [3];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_op(input int s, input logic [6:0] op);
    op_a = (s == 0) ? op : NOP;
    op_b = (s == 1) ? op : NOP;
    op_c = (s == 2) ? op : NOP;
  endtask

  // d = cycles from the first REQ cycle to the RDY pulse (large value means RDY never comes).
  task automatic access(input string tag, input int s, input bit st, input logic [2:0] fn3,
                        input logic [31:0] a, input logic [63:0] wd, input logic [63:0] rd,
                        input int d);
    int          xb, nb, off, r, to, k, c, strobes, exp_hold, exp_str;
    bit          illegal, mis, flt, done, seen;
    logic [1:0]  cause;
    logic [63:0] be_e, mw_e, ld_e, keep, rdv;
    xb  = PXLEN[s] / 8;
    nb  = 1 << fn3[1:0];
    off = a % xb;
    r   = PREQ[s];
    to  = PTO[s];
    illegal  = (fn3 == 3'd7) || (st && fn3[2]) ||
               (PXLEN[s] == 32 && (fn3 == 3'd3 || fn3 == 3'd6));
    mis      = (off % nb) != 0;
    flt      = 1'b1;
    cause    = 2'b00;
    exp_hold = 1;
    exp_str  = 0;
    if (illegal) cause = 2'b11;
    else if (mis && PTRAP[s] != 0) cause = 2'b01;
    else begin
      exp_str = r;
      if (mis) off = off - off % nb;
      if (d < r) begin
        flt = 1'b0;
        exp_hold = 1 + r;
      end else begin
        k = d - r + 1;
        if (to != 0 && k > to) begin
          cause = 2'b10;
          exp_hold = 1 + r + to;
        end else begin
          flt = 1'b0;
          exp_hold = 1 + r + k;
        end
      end
    end
    be_e = ((64'd1 << nb) - 64'd1) << off;
    mw_e = '0;
    for (int i = 0; i < xb; i++) mw_e[8*i +: 8] = wd[8*(i % nb) +: 8];
    rdv  = (xb == 4) ? (rd & 64'hFFFF_FFFF) : rd;
    ld_e = rdv >> (8 * off);
    if (nb < 8) begin
      keep = (64'd1 << (8 * nb)) - 64'd1;
      ld_e = ld_e & keep;
      if (!fn3[2] && ld_e[8*nb-1]) ld_e = ld_e | ~keep;
    end
    if (xb == 4) ld_e = ld_e & 64'hFFFF_FFFF;
    if (!st && !flt) m_ldata[s] = ld_e;
    if (flt) m_cause[s] = cause;

    @(posedge clk); #1;
    sel = s; f3 = fn3; addr = a; wdata = wd; rdata = rd; rdy = 1'b0;
    set_op(s, st ? STORE : LOAD);
    strobes = 0; done = 1'b0; seen = 1'b0; c = 0;
    while (!done && c < 64) begin
      rdy = (c == 1 + d);
      @(negedge clk);
      if (o_rreq || o_cwe) begin
        strobes++;
        if (!seen) begin
          seen = 1'b1;
          check({tag, "/dir"}, {o_rreq, o_cwe}, st ? 2'b01 : 2'b10);
          check({tag, "/be"}, o_be, be_e);
          check({tag, "/maddr"}, o_maddr, a & ~32'(xb - 1));
          if (st) check({tag, "/mwdata"}, o_mwdata, mw_e);
        end
      end
      if (!o_hold) done = 1'b1;
      else begin
        c++;
        @(posedge clk); #1;
      end
    end
    check({tag, "/ended"}, done, 1'b1);
    check({tag, "/hold_cycles"}, c, exp_hold);
    check({tag, "/fault"}, o_fault, flt);
    check({tag, "/lwe"}, o_lwe, !st && !flt);
    check({tag, "/cause"}, o_cause, m_cause[s]);
    check({tag, "/strobes"}, strobes, exp_str);
    check({tag, "/ldata"}, o_ldata, m_ldata[s]);
    @(posedge clk); #1;
    set_op(s, NOP);
    rdy = 1'b0;
    @(negedge clk);
    check({tag, "/after"}, {o_hold, o_fault, o_lwe, o_rreq, o_cwe}, 5'b0);
  endtask

  int          s, d;
  bit          st;
  logic [2:0]  fn3;
  logic [31:0] a;
  logic [63:0] wd, rd;

  initial begin
    rst = 1'b1; sel = 0; f3 = 3'b010; addr = '0; wdata = '0; rdata = '0; rdy = 1'b0;
    set_op(0, LOAD);
    for (int i = 0; i < 3; i++) begin
      m_ldata[i] = '0;
      m_cause[i] = 2'b00;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hold_forced", o_hold, 1'b0);
    @(posedge clk); #1;
    set_op(0, NOP);
    rst = 1'b0;
    @(negedge clk);
    check("rst_strobes", {o_hold, o_rreq, o_cwe, o_lwe, o_fault, o_cause}, 7'b0);
    check("rst_be", o_be, 8'h0);
    check("rst_maddr", o_maddr, 32'h0);
    check("rst_mwdata", o_mwdata, 64'h0);
    check("rst_ldata", o_ldata, 64'h0);

    access("lw", 0, 0, 3'b010, 32'h104, 64'h0, 64'hDEAD_BEEF, 2);
    check("lw_value", o_ldata, 64'hDEAD_BEEF);
    access("lb", 0, 0, 3'b000, 32'h103, 64'h0, 64'h80FF_0000, 1);
    check("lb_value", o_ldata, 64'hFFFF_FF80);
    access("lbu", 0, 0, 3'b100, 32'h103, 64'h0, 64'h80FF_0000, 0);
    check("lbu_value", o_ldata, 64'h0000_0080);
    access("sh", 0, 1, 3'b001, 32'h102, 64'h1234, 64'h0, 0);
    access("lw_mis_trap", 0, 0, 3'b010, 32'h101, 64'h0, 64'h1122_3344, 1);
    check("mis_cause_value", o_cause, 2'b01);
    access("lw_mis_fix", 1, 0, 3'b010, 32'h101, 64'h0, 64'h5566_7788, 1);
    access("to_never", 0, 0, 3'b010, 32'h200, 64'h0, 64'hCAFE, 1000);
    access("to_rdy_last", 0, 0, 3'b010, 32'h200, 64'h0, 64'hBEEF_0001, 5);
    access("ld_on_32", 0, 0, 3'b011, 32'h300, 64'h0, 64'h1, 0);
    access("sbu_illegal", 1, 1, 3'b100, 32'h300, 64'h77, 64'h0, 0);
    access("ld64", 2, 0, 3'b011, 32'h1000, 64'h0, 64'h8877_6655_4433_2211, 0);
    access("lw64_hi", 2, 0, 3'b010, 32'h1004, 64'h0, 64'h8000_0000_0000_0000, 2);
    access("sb64", 2, 1, 3'b000, 32'h1007, 64'hA5, 64'h0, 3);

    // Reset during WAIT must abort the access at once.
    @(posedge clk); #1;
    sel = 0; f3 = 3'b010; addr = 32'h400; rdy = 1'b0;
    set_op(0, LOAD);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_rst_wait", {o_hold, o_rreq, o_cwe}, 3'b100);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_wait_hold", {o_hold, o_rreq, o_cwe}, 3'b000);
    @(posedge clk); #1;
    rst = 1'b0;
    set_op(0, NOP);
    for (int i = 0; i < 3; i++) begin
      m_ldata[i] = '0;
      m_cause[i] = 2'b00;
    end
    @(negedge clk);
    check("post_rst_idle", {o_hold, o_rreq, o_cwe, o_fault, o_lwe, o_cause}, 7'b0);
    check("post_rst_ldata", o_ldata, 64'h0);

    for (int i = 0; i < 40; i++) begin
      s   = $urandom_range(0, 2);
      st  = 1'($urandom_range(0, 1));
      fn3 = 3'($urandom_range(0, 7));
      a   = $urandom;
      if ($urandom_range(0, 2) != 0) a[2:0] = 3'b000;
      wd  = {$urandom, $urandom};
      rd  = {$urandom, $urandom};
      d   = ($urandom_range(0, 9) == 9) ? 1000 : int'($urandom_range(0, 7));
      access("rand", s, st, fn3, a, wd, rd, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
